uart_fifo: RTL
==============

UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 Parameter TX_DEPTH, default 8: TX FIFO entries; power of two, 2..256.
REQ-002 Parameter RX_DEPTH, default 8: RX FIFO entries; power of two, 2..256.
REQ-003 Parameter BAUD_RESET, default 16'd434: BAUD register reset value.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 select  input  1  bus access request, held until ready.
REQ-007 wstrb  input  4  byte write strobes; 0 = read.
REQ-008 addr  input  5  register byte offset.
REQ-009 data_i  input  32  write data.
REQ-010 ready  output  1  access-complete pulse.
REQ-011 data_o  output  32  read data, valid while ready=1.
REQ-012 rx  input  1  serial in, asynchronous.
REQ-013 tx  output  1  serial out, idle high.
REQ-014 irq  output  1  level interrupt, OR of enabled status flags.

Function
REQ-015 Registers: 0x00 CTRL (bit0 LOOPBACK, bit1 EN, bit2 STOP2, bits[4:3] PARITY), 0x04 BAUD[15:0] clocks per bit, 0x08 STATUS, 0x0C IRQ_EN, 0x10 TXDATA (write pushes [7:0]; reads 0), 0x14 RXDATA (read pops; bit8 = valid), 0x18 LEVEL (tx count [8:0], rx count [24:16]); other offsets read 0, ignore writes.
REQ-016 STATUS bits: 0 tx_empty, 1 tx_full, 2 rx_empty, 3 rx_full, 4 tx_ovf, 5 rx_ovr, 6 frame_err, 7 parity_err; bits 4-7 sticky, write-1-to-clear.
REQ-017 Access accepted when select=1 and ready=0; ready=1 exactly one cycle later for one cycle; write/pop/push take effect on that edge; back-to-back accesses are allowed.
REQ-018 Only bytes with wstrb set are written; BAUD writes below 4 clamp to 4.
REQ-019 TX FSM IDLE->START->DATA(8 bits, LSB first)->PARITY (if enabled)->STOP (1 or 2 bits)->IDLE; each state lasts BAUD clocks; it leaves IDLE only when EN=1 and the TX FIFO is not empty.
REQ-020 rx passes through a 2-flop synchronizer; RX FSM IDLE->START on falling edge; start bit re-checked at BAUD/2 and returns to IDLE if high; DATA/PARITY/STOP sampled mid-bit.
REQ-021 STOP sampled low: frame_err set; the byte is still pushed.
REQ-022 Push to a full TX FIFO: data dropped, tx_ovf set; received byte with the RX FIFO full: byte dropped, rx_ovr set, FIFO unchanged.
REQ-023 Read RXDATA while empty: returns 0 with bit8=0; no pointer change.
REQ-024 Push and pop on the same edge on a non-empty, non-full FIFO: count unchanged.
REQ-025 EN cleared mid-frame: both FSMs go to IDLE on the next edge, tx=1, FIFO contents retained.
REQ-026 BAUD write mid-frame takes effect at the next bit boundary.
REQ-027 LOOPBACK=1: RX input is the internal tx; the tx pin is held at 1.

Reset
REQ-028 On reset_n=0: ready=0, data_o=0, tx=1, irq=0, CTRL=0, IRQ_EN=0, BAUD=BAUD_RESET, FIFOs empty, sticky flags 0, FSMs IDLE, synchronizer flops 1.

Configuration
REQ-029 Macro UART_PARITY_EN defined: PARITY 00 none, 01 even, 10 odd, 11 none; parity_err set on mismatch.
REQ-030 Macro UART_PARITY_EN undefined: PARITY bits read 0, no parity bit is sent or checked, parity_err is constant 0.

Structure
REQ-031 Package uart_pkg holds register offset constants, STATUS bit indices and the TX/RX FSM state enums.
REQ-032 One sub-module sync_fifo (parameters WIDTH, DEPTH) is instantiated twice: TX FIFO 8 bits wide, RX FIFO 9 bits wide (data plus frame_err tag).

Verification
REQ-033 Write BAUD=10, read back -> data_o=0x0000000A on the ready cycle, and ready is high for 1 cycle.
REQ-034 CTRL=0x2, push 0x61 then 0x65 -> tx shows start, LSB-first bits, stop for each byte, 10 clocks per bit, frames back to back.
REQ-035 LOOPBACK+EN, push 0x00..0x07 (depth 8) -> RXDATA returns 0x100..0x107 in order, and rx_empty=1 after the last read.
REQ-036 EN=0, push 9 bytes -> tx_full=1, tx_ovf=1, LEVEL tx=8; write 0x10 to STATUS -> tx_ovf=0.
REQ-037 Drive rx with 0x55 and its stop bit low -> frame_err=1; with IRQ_EN bit6=1 -> irq=1.
REQ-038 With UART_PARITY_EN defined, PARITY=01, loopback 0x07 -> parity bit 1 on the line, parity_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART with FIFOs: register map, STATUS bit positions,
// FSM state encodings and the parity helper.
package uart_pkg;

  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_BAUD   = 5'h04;
  localparam logic [4:0] ADDR_STATUS = 5'h08;
  localparam logic [4:0] ADDR_IRQ_EN = 5'h0C;
  localparam logic [4:0] ADDR_TXDATA = 5'h10;
  localparam logic [4:0] ADDR_RXDATA = 5'h14;
  localparam logic [4:0] ADDR_LEVEL  = 5'h18;

  localparam int ST_TX_EMPTY   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_TX_OVF     = 4;
  localparam int ST_RX_OVR     = 5;
  localparam int ST_FRAME_ERR  = 6;
  localparam int ST_PARITY_ERR = 7;

  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // Even parity makes the total count of ones even, so the bit is the XOR of the data.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_fifo_if.sv
// Register bus between a host and the UART: one-cycle-later ready handshake.
interface uart_fifo_if;
  logic        select;
  logic [3:0]  wstrb;
  logic [4:0]  addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;

  modport master (output select, wstrb, addr, data_i, input ready, data_o);
  modport slave  (input select, wstrb, addr, data_i, output ready, data_o);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; pushes when full and pops when
// empty are ignored, so callers only need to watch the flags.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo.sv
// UART with TX/RX FIFOs behind a small register bus. Build with UART_PARITY_EN
// defined to add an optional even/odd parity bit to every frame.
module uart_fifo #(
  parameter int          TX_DEPTH   = 8,
  parameter int          RX_DEPTH   = 8,
  parameter logic [15:0] BAUD_RESET = 16'd434
) (
  input  logic       clk,
  input  logic       reset_n,
  uart_fifo_if.slave bus,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);
  import uart_pkg::*;

  localparam int TXW = $clog2(TX_DEPTH) + 1;
  localparam int RXW = $clog2(RX_DEPTH) + 1;

  logic        loopback, en, stop2;
  logic [1:0]  parity;
  logic        parity_en;
  logic [15:0] baud, baud_new;
  logic [7:0]  irq_en;
  logic        tx_ovf, rx_ovr, frame_err, parity_err;
  logic [7:0]  status;
  logic [31:0] rd_mux;

  logic        accept, wr, rd, ctrl_wr, status_w1c, tx_push, rx_pop;
  logic [7:0]  tx_rdata;
  logic [8:0]  rx_rdata;
  logic [TXW-1:0] tx_count;
  logic [RXW-1:0] rx_count;
  logic        tx_empty, tx_full, rx_empty, rx_full;

  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_par, tx_second, tx_line, tx_load, tx_last_stop;

  rx_state_t   rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_meta, rx_s, rx_prev;
  logic        rx_push, rx_frame_set, rx_par_err;
  logic [8:0]  rx_push_data;
  logic        unused_bits;

  assign accept     = bus.select && !bus.ready;
  assign wr         = accept && (bus.wstrb != 4'b0000);
  assign rd         = accept && (bus.wstrb == 4'b0000);
  assign ctrl_wr    = wr && (bus.addr == ADDR_CTRL) && bus.wstrb[0];
  assign status_w1c = wr && (bus.addr == ADDR_STATUS) && bus.wstrb[0];
  assign tx_push    = wr && (bus.addr == ADDR_TXDATA) && bus.wstrb[0];
  assign rx_pop     = rd && (bus.addr == ADDR_RXDATA);
  assign unused_bits = ^{bus.data_i[31:16], bus.wstrb[3:2]};

  assign baud_new = {bus.wstrb[1] ? bus.data_i[15:8] : baud[15:8],
                     bus.wstrb[0] ? bus.data_i[7:0]  : baud[7:0]};

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(tx_push), .pop(tx_load),
    .wdata(bus.data_i[7:0]), .rdata(tx_rdata), .count(tx_count),
    .empty(tx_empty), .full(tx_full)
  );

  // RX entries carry the frame error tag above the data byte.
  sync_fifo #(.WIDTH(9), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(rx_pop),
    .wdata(rx_push_data), .rdata(rx_rdata), .count(rx_count),
    .empty(rx_empty), .full(rx_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loopback <= 1'b0;
      en       <= 1'b0;
      stop2    <= 1'b0;
      baud     <= BAUD_RESET;
      irq_en   <= 8'h00;
    end else if (wr) begin
      if (ctrl_wr) {stop2, en, loopback} <= bus.data_i[2:0];
      if (bus.addr == ADDR_BAUD && bus.wstrb[1:0] != 2'b00)
        baud <= (baud_new < 16'd4) ? 16'd4 : baud_new;
      if (bus.addr == ADDR_IRQ_EN && bus.wstrb[0]) irq_en <= bus.data_i[7:0];
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     parity <= 2'b00;
    else if (ctrl_wr) parity <= bus.data_i[4:3];
  end
  assign parity_en = (parity == PAR_EVEN) || (parity == PAR_ODD);
`else
  assign parity    = 2'b00;
  assign parity_en = 1'b0;
`endif

  // Sticky error flags: a new event on the same edge wins over a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_ovf     <= 1'b0;
      rx_ovr     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      tx_ovf     <= (tx_push && tx_full) || (tx_ovf && !(status_w1c && bus.data_i[ST_TX_OVF]));
      rx_ovr     <= (rx_push && rx_full) || (rx_ovr && !(status_w1c && bus.data_i[ST_RX_OVR]));
      frame_err  <= rx_frame_set || (frame_err && !(status_w1c && bus.data_i[ST_FRAME_ERR]));
      parity_err <= (parity_en && rx_par_err) ||
                    (parity_err && !(status_w1c && bus.data_i[ST_PARITY_ERR]));
    end
  end

  assign status = {parity_err, frame_err, rx_ovr, tx_ovf, rx_full, rx_empty, tx_full, tx_empty};
  assign irq    = |(status & irq_en);

  always_comb begin
    rd_mux = 32'h0;
    case (bus.addr)
      ADDR_CTRL:   rd_mux = {27'b0, parity, stop2, en, loopback};
      ADDR_BAUD:   rd_mux = {16'b0, baud};
      ADDR_STATUS: rd_mux = {24'b0, status};
      ADDR_IRQ_EN: rd_mux = {24'b0, irq_en};
      ADDR_RXDATA: if (!rx_empty) rd_mux = {22'b0, rx_rdata[8], 1'b1, rx_rdata[7:0]};
      ADDR_LEVEL:  rd_mux = {7'b0, 9'(rx_count), 7'b0, 9'(tx_count)};
      default:     rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ready  <= 1'b0;
      bus.data_o <= 32'h0;
    end else begin
      bus.ready  <= accept;
      bus.data_o <= rd ? rd_mux : 32'h0;
    end
  end

  // A new byte is fetched either from idle or straight out of the final stop bit.
  assign tx_last_stop = (tx_state == TX_STOP) && (tx_cnt == 16'd0) && (!stop2 || tx_second);
  assign tx_load      = en && !tx_empty && ((tx_state == TX_IDLE) || tx_last_stop);
  assign tx           = loopback ? 1'b1 : tx_line;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= 16'd0;
      tx_bit    <= 3'd0;
      tx_shift  <= 8'h00;
      tx_par    <= 1'b0;
      tx_second <= 1'b0;
      tx_line   <= 1'b1;
    end else if (!en) begin
      tx_state <= TX_IDLE;
      tx_line  <= 1'b1;
      tx_cnt   <= 16'd0;
    end else if (tx_load) begin
      tx_state <= TX_START;
      tx_line  <= 1'b0;
      tx_shift <= tx_rdata;
      tx_par   <= parity_bit(tx_rdata, parity);
      tx_cnt   <= baud - 16'd1;
    end else if (tx_state == TX_IDLE) begin
      tx_line <= 1'b1;
    end else if (tx_cnt != 16'd0) begin
      tx_cnt <= tx_cnt - 16'd1;
    end else begin
      tx_cnt <= baud - 16'd1;
      case (tx_state)
        TX_START: begin
          tx_state <= TX_DATA;
          tx_bit   <= 3'd0;
          tx_line  <= tx_shift[0];
        end
        TX_DATA: begin
          if (tx_bit == 3'd7) begin
            tx_state  <= parity_en ? TX_PARITY : TX_STOP;
            tx_line   <= parity_en ? tx_par : 1'b1;
            tx_second <= 1'b0;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= tx_shift >> 1;
            tx_line  <= tx_shift[1];
          end
        end
        TX_PARITY: begin
          tx_state  <= TX_STOP;
          tx_line   <= 1'b1;
          tx_second <= 1'b0;
        end
        TX_STOP: begin
          if (stop2 && !tx_second) tx_second <= 1'b1;
          else                     tx_state  <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= loopback ? tx_line : rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // The start bit is re-checked half a bit in, which lines every later sample up mid-bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= 16'd0;
      rx_bit       <= 3'd0;
      rx_shift     <= 8'h00;
      rx_push      <= 1'b0;
      rx_push_data <= 9'h000;
      rx_frame_set <= 1'b0;
      rx_par_err   <= 1'b0;
    end else begin
      rx_push      <= 1'b0;
      rx_frame_set <= 1'b0;
      rx_par_err   <= 1'b0;
      if (!en) begin
        rx_state <= RX_IDLE;
      end else if (rx_state == RX_IDLE) begin
        if (rx_prev && !rx_s) begin
          rx_state <= RX_START;
          rx_cnt   <= {1'b0, baud[15:1]} - 16'd1;
        end
      end else if (rx_cnt != 16'd0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt <= baud - 16'd1;
        case (rx_state)
          RX_START: begin
            if (rx_s) rx_state <= RX_IDLE;
            else begin
              rx_state <= RX_DATA;
              rx_bit   <= 3'd0;
            end
          end
          RX_DATA: begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= parity_en ? RX_PARITY : RX_STOP;
          end
          RX_PARITY: begin
            rx_par_err <= (rx_s != parity_bit(rx_shift, parity));
            rx_state   <= RX_STOP;
          end
          RX_STOP: begin
            rx_push      <= 1'b1;
            rx_push_data <= {!rx_s, rx_shift};
            rx_frame_set <= !rx_s;
            rx_state     <= RX_IDLE;
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule
